// File: rtl/pong_paddle_input_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pong_pkg
//  Description : Shared types and constants for the paddle input stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

   // Debounce channel states; level output is high in PRESSED and RELEASE_WAIT
   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } btn_state_t;

   // 10 ms of stability at a 100 MHz system clock
   localparam int DEBOUNCE_DEFAULT = 1_000_000;

endpackage
`default_nettype wire

// File: rtl/pong_paddle_input_if.sv
`default_nettype none
// ============================================================================
//  Module      : pong_paddle_input_if
//  Description : Raw paddle buttons in, debounced levels and hit pulses out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pong_paddle_input_if;

   logic b1;
   logic b2;
   logic b1_level;
   logic b2_level;
   logic b1_hit;
   logic b2_hit;

   // Side that owns the raw buttons and consumes the conditioned outputs
   modport master (
      output b1,
      output b2,
      input  b1_level,
      input  b2_level,
      input  b1_hit,
      input  b2_hit
   );

   // Conditioning stage itself
   modport slave (
      input  b1,
      input  b2,
      output b1_level,
      output b2_level,
      output b1_hit,
      output b2_hit
   );

endinterface
`default_nettype wire

// File: rtl/pong_btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : pong_btn_debounce
//  Description : One button channel: 2-flop synchroniser, 4-state debounce
//                FSM with stability counter, registered level and hit pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module pong_btn_debounce
   import pong_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic level,
   output logic hit
);

   // Terminal count: the FSM leaves a wait state here, so cnt never wraps
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_meta_q, sync_meta_d;
   logic             sync_q, sync_d;
   btn_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             hit_q, hit_d;

   // State register: synchroniser, FSM, counter and both outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_meta_q <= 1'b0;
         sync_q      <= 1'b0;
         state_q     <= IDLE;
         cnt_q       <= '0;
         level_q     <= 1'b0;
         hit_q       <= 1'b0;
      end else begin
         sync_meta_q <= sync_meta_d;
         sync_q      <= sync_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         level_q     <= level_d;
         hit_q       <= hit_d;
      end
   end

   // Next-state logic; hit fires only on the PRESS_WAIT -> PRESSED edge
   always_comb begin
      sync_meta_d = btn;
      sync_d      = sync_meta_q;
      state_d     = state_q;
      cnt_d       = cnt_q;
      hit_d       = 1'b0;

      case (state_q)
         IDLE: begin
            if (sync_q) begin
               state_d = PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!sync_q) begin
               state_d = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               state_d = PRESSED;
               hit_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PRESSED: begin
            if (!sync_q) begin
               state_d = RELEASE_WAIT;
               cnt_d   = '0;
            end
         end
         RELEASE_WAIT: begin
            // Returning high is release bounce: back to PRESSED, no new hit
            if (sync_q) begin
               state_d = PRESSED;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      // Level follows the state being entered so it is registered with it
      level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
   end

   assign level = level_q;
   assign hit   = hit_q;

endmodule
`default_nettype wire

// File: rtl/pong_paddle_input.sv
`default_nettype none
// ============================================================================
//  Module      : pong_paddle_input
//  Description : Two independent debounced paddle buttons for the ping-pong
//                game controller. No arbitration between channels.
//  Revision    : 1.0 - initial release
// ============================================================================
module pong_paddle_input
   import pong_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic                clk,
   input  logic                reset,
   pong_paddle_input_if.slave  bus
);

   pong_btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_btn1 (
      .clk   (clk),
      .reset (reset),
      .btn   (bus.b1),
      .level (bus.b1_level),
      .hit   (bus.b1_hit)
   );

   pong_btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_btn2 (
      .clk   (clk),
      .reset (reset),
      .btn   (bus.b2),
      .level (bus.b2_level),
      .hit   (bus.b2_hit)
   );

endmodule
`default_nettype wire

// File: tb/tb_pong_paddle_input.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pong_paddle_input
//  Description : Self-checking bench for pong_paddle_input, DEBOUNCE_CYCLES=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pong_paddle_input;

   localparam int D = 4;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_pass;

   pong_paddle_input_if bus ();

   pong_paddle_input #(
      .DEBOUNCE_CYCLES (D)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------------------
   // Reference model: a button is accepted once the synchronised value
   // (raw delayed by two samples) has held for D+1 consecutive edges.
   // ------------------------------------------------------------------
   typedef struct {
      bit d1;
      bit d2;
      bit val;
      int len;
      bit level;
      bit hit;
   } mdl_t;

   function automatic mdl_t mdl_reset();
      mdl_t s;
      s.d1 = 1'b0; s.d2 = 1'b0; s.val = 1'b0; s.len = 0;
      s.level = 1'b0; s.hit = 1'b0;
      return s;
   endfunction

   function automatic mdl_t mdl_step(mdl_t s, bit raw);
      mdl_t n;
      bit   seen;
      n    = s;
      seen = s.d2;
      n.d2 = s.d1;
      n.d1 = raw;
      if (s.len > 0 && seen == s.val) begin
         if (s.len < 1000000) n.len = s.len + 1;
      end else begin
         n.val = seen;
         n.len = 1;
      end
      n.hit = 1'b0;
      if (!s.level && seen && n.len == D + 1) begin
         n.level = 1'b1;
         n.hit   = 1'b1;
      end else if (s.level && !seen && n.len == D + 1) begin
         n.level = 1'b0;
      end
      return n;
   endfunction

   mdl_t m1, m2;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m1 <= mdl_reset();
         m2 <= mdl_reset();
      end else begin
         m1 <= mdl_step(m1, bus.b1);
         m2 <= mdl_step(m2, bus.b2);
      end
   end

   // ------------------------------------------------------------------
   // Checking helpers
   // ------------------------------------------------------------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [3:0] outs();
      return {bus.b1_level, bus.b1_hit, bus.b2_level, bus.b2_hit};
   endfunction

   // ------------------------------------------------------------------
   // Directed vector table: drive inputs, wait n edges, then compare the
   // final levels, hit pulses seen and level transitions seen.
   // ------------------------------------------------------------------
   typedef struct {
      bit b1;
      bit b2;
      int n;
      bit l1;
      bit l2;
      int h1;
      int h2;
      int t1;
      int t2;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit b1, bit b2, int n, bit l1, bit l2,
                               int h1, int h2, int t1, int t2);
      vec_t v;
      v.b1 = b1; v.b2 = b2; v.n = n; v.l1 = l1; v.l2 = l2;
      v.h1 = h1; v.h2 = h2; v.t1 = t1; v.t2 = t2;
      return v;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c1, c2, g1, g2;
      bit p1, p2;
      int left1, left2, rst_left;

      n_checks = 0;
      n_pass   = 0;
      reset    = 1'b1;
      bus.b1   = 1'b0;
      bus.b2   = 1'b0;

      // clean press of b1 with release
      tbl.push_back(mk(1,0,  6, 0,0, 0,0, 0,0));
      tbl.push_back(mk(1,0,  1, 1,0, 1,0, 1,0));
      tbl.push_back(mk(1,0, 33, 1,0, 0,0, 0,0));
      tbl.push_back(mk(0,0,  6, 1,0, 0,0, 0,0));
      tbl.push_back(mk(0,0,  1, 0,0, 0,0, 1,0));
      tbl.push_back(mk(0,0,  5, 0,0, 0,0, 0,0));
      // press bounce 1,0,1,0,1 with 2-cycle widths
      tbl.push_back(mk(1,0,  2, 0,0, 0,0, 0,0));
      tbl.push_back(mk(0,0,  2, 0,0, 0,0, 0,0));
      tbl.push_back(mk(1,0,  2, 0,0, 0,0, 0,0));
      tbl.push_back(mk(0,0,  2, 0,0, 0,0, 0,0));
      tbl.push_back(mk(1,0,  6, 0,0, 0,0, 0,0));
      tbl.push_back(mk(1,0,  1, 1,0, 1,0, 1,0));
      tbl.push_back(mk(1,0,  5, 1,0, 0,0, 0,0));
      tbl.push_back(mk(0,0, 12, 0,0, 0,0, 1,0));
      // release bounce on b2, then a real release
      tbl.push_back(mk(0,1,  7, 0,1, 0,1, 0,1));
      tbl.push_back(mk(0,1,  5, 0,1, 0,0, 0,0));
      tbl.push_back(mk(0,0,  3, 0,1, 0,0, 0,0));
      tbl.push_back(mk(0,1, 10, 0,1, 0,0, 0,0));
      tbl.push_back(mk(0,0,  6, 0,1, 0,0, 0,0));
      tbl.push_back(mk(0,0,  1, 0,0, 0,0, 0,1));
      tbl.push_back(mk(0,0,  3, 0,0, 0,0, 0,0));
      // simultaneous press of both buttons
      tbl.push_back(mk(1,1,  6, 0,0, 0,0, 0,0));
      tbl.push_back(mk(1,1,  1, 1,1, 1,1, 1,1));
      tbl.push_back(mk(1,1,  5, 1,1, 0,0, 0,0));
      tbl.push_back(mk(0,0, 12, 0,0, 0,0, 1,1));
      // long hold: one hit, no auto-repeat
      tbl.push_back(mk(1,0,  7, 1,0, 1,0, 1,0));
      tbl.push_back(mk(1,0,1000, 1,0, 0,0, 0,0));
      tbl.push_back(mk(0,0, 12, 0,0, 0,0, 1,0));

      // reset state
      repeat (3) @(negedge clk);
      check("reset_hold", 32'(outs()), 32'd0);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("after_reset_idle", 32'(outs()), 32'd0);

      // directed table
      for (int i = 0; i < tbl.size(); i++) begin
         bus.b1 = tbl[i].b1;
         bus.b2 = tbl[i].b2;
         c1 = 0; c2 = 0; g1 = 0; g2 = 0;
         p1 = bus.b1_level;
         p2 = bus.b2_level;
         repeat (tbl[i].n) begin
            @(negedge clk);
            if (bus.b1_hit) c1++;
            if (bus.b2_hit) c2++;
            if (bus.b1_level != p1) g1++;
            if (bus.b2_level != p2) g2++;
            p1 = bus.b1_level;
            p2 = bus.b2_level;
         end
         check($sformatf("tbl%0d_level", i), 32'({bus.b1_level, bus.b2_level}),
               32'({tbl[i].l1, tbl[i].l2}));
         check($sformatf("tbl%0d_hits", i), 32'(c1 * 256 + c2),
               32'(tbl[i].h1 * 256 + tbl[i].h2));
         check($sformatf("tbl%0d_toggles", i), 32'(g1 * 256 + g2),
               32'(tbl[i].t1 * 256 + tbl[i].t2));
      end

      // reset during PRESS_WAIT with b1 held
      bus.b1 = 1'b1;
      repeat (4) @(negedge clk);
      check("rst_pw_before", 32'(outs()), 32'd0);
      reset = 1'b1;
      #1;
      check("rst_pw_now", 32'(outs()), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      check("rst_pw_lat6", 32'(outs()), 32'd0);
      @(negedge clk);
      check("rst_pw_hit", 32'(outs()), 32'b1000 | 32'b0100);
      @(negedge clk);
      check("rst_pw_width", 32'(outs()), 32'b1000);
      repeat (3) @(negedge clk);
      // reset during PRESSED with b1 still held
      reset = 1'b1;
      #1;
      check("rst_pr_now", 32'(outs()), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      check("rst_pr_lat6", 32'(outs()), 32'd0);
      @(negedge clk);
      check("rst_pr_hit", 32'(outs()), 32'b1100);
      @(negedge clk);
      check("rst_pr_width", 32'(outs()), 32'b1000);
      bus.b1 = 1'b0;
      repeat (12) @(negedge clk);
      check("rst_release", 32'(outs()), 32'd0);

      // randomized bursts against the reference model
      left1 = 0; left2 = 0; rst_left = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         check($sformatf("rand%0d", cyc), 32'(outs()),
               32'({m1.level, m1.hit, m2.level, m2.hit}));
         if (reset) begin
            rst_left--;
            if (rst_left <= 0) reset = 1'b0;
         end else if ($urandom_range(0, 299) == 0) begin
            reset    = 1'b1;
            rst_left = int'($urandom_range(1, 2));
         end
         if (left1 == 0) begin
            bus.b1 = 1'($urandom_range(0, 1));
            left1  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                                 : int'($urandom_range(5, 16));
         end
         left1--;
         if (left2 == 0) begin
            bus.b2 = 1'($urandom_range(0, 1));
            left2  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                                 : int'($urandom_range(5, 16));
         end
         left2--;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
